dram_err_responder: RTL and testbench
=====================================

DRAM_ERR_RESPONDER -- requirements
Module: dram_err_responder

Interface
REQ-001 SHALL have parameter IdWidth, default 6, AXI ID width.
REQ-002 SHALL have parameter DataWidth, default 64, R data width (multiple of 8).
REQ-003 SHALL have parameter MaxTrans, default 4, depth of each of the AW, B and AR queues (>=1).
REQ-004 SHALL have parameter Resp, default 2'b11 (DECERR), value driven on b_resp_o and r_resp_o.
REQ-005 SHALL have parameter RespData, default 64'hCA11AB1EBADCAB1E, pattern driven on r_data_o.
REQ-006 SHALL have parameter CntWidth, default 16, error counter width.
REQ-007 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- aw_valid_i / aw_ready_o  in/out  1/1  AW handshake
- aw_id_i  in  IdWidth  write ID
- w_valid_i / w_ready_o  in/out  1/1  W handshake
- w_last_i  in  1  last W beat
- b_valid_o / b_ready_i  out/in  1/1  B handshake
- b_id_o  out  IdWidth  B ID
- b_resp_o  out  2  B response
- ar_valid_i / ar_ready_o  in/out  1/1  AR handshake
- ar_id_i  in  IdWidth  read ID
- ar_len_i  in  8  burst length minus one
- r_valid_o / r_ready_i  out/in  1/1  R handshake
- r_id_o  out  IdWidth  R ID
- r_data_o  out  DataWidth  R data
- r_resp_o  out  2  R response
- r_last_o  out  1  last R beat
- clr_i  in  1  synchronous counter clear
- err_cnt_o  out  CntWidth  completed error transactions
- busy_o  out  1  transactions outstanding

Function
REQ-008 SHALL use AW queue: aw_ready_o = AW queue not full; an accepted aw_id_i is pushed.
REQ-009 SHALL use w_ready_o = AW queue not empty AND B queue not full; data is discarded.
REQ-010 SHALL, on a W handshake with w_last_i=1, pop the AW head and push its ID into the B queue in the same cycle.
REQ-011 SHALL use b_valid_o = B queue not empty, b_id_o = B head, b_resp_o = Resp; pop on b_valid_o & b_ready_i.
REQ-012 SHALL accept W no earlier than the cycle after the matching AW handshake; b_valid_o SHALL rise the cycle after the w_last handshake.
REQ-013 SHALL use AR queue (ID, len): ar_ready_o = AR queue not full.
REQ-014 SHALL use R FSM states IDLE and BURST: in IDLE with AR queue non-empty, pop head, load ID and beat counter = len, go to BURST next cycle.
REQ-015 SHALL, in BURST, drive r_valid_o=1, r_id_o = loaded ID, r_resp_o = Resp, r_last_o = (counter==0); each R handshake decrements counter; handshake with counter==0 returns to IDLE.
REQ-016 SHALL hold r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o stable while r_ready_i=0.
REQ-017 SHALL give first r_valid_o two cycles after AR handshake into empty queue; exactly one IDLE cycle between consecutive bursts.
REQ-018 SHALL drive r_data_o = RespData replicated LSB-first to DataWidth, truncated when DataWidth<64; r_data_o, r_resp_o, r_last_o, r_id_o SHALL be 0 outside BURST.
REQ-019 SHALL treat queue push and pop in the same cycle when full as pop-only (ready low, no push); simultaneous push and pop when non-full keep occupancy constant.
REQ-020 SHALL increment err_cnt_o by 1 per B handshake and per R handshake with r_last_o=1; both in one cycle SHALL add 2.
REQ-021 SHALL saturate err_cnt_o at all-ones (no wrap, including +2 from all-ones minus one).
REQ-022 SHALL clear err_cnt_o to 0 on clr_i=1, overriding any same-cycle increment.
REQ-023 SHALL drive busy_o = any queue non-empty OR R FSM in BURST.
REQ-024 SHALL keep write and read paths independent; neither SHALL stall the other.

Reset
REQ-025 SHALL, on rst_i=1 (asynchronous assert, any cycle including mid-burst), empty all queues, set FSM to IDLE, err_cnt_o=0, and drive all ready/valid/busy outputs to 0 apart from aw_ready_o and ar_ready_o, which SHALL be 1; in-flight transactions are dropped without response.

Verification
REQ-026 AW id=5, then W 3 beats (last on 3rd), b_ready_i=1 -> b_valid_o one cycle after last, b_id_o=5, b_resp_o=2'b11, err_cnt_o=1.
REQ-027 AR id=3 len=3, r_ready_i=1 -> r_valid_o at AR+2, 4 beats data 64'hCA11AB1EBADCAB1E, r_last_o on beat 4 only, err_cnt_o=1.
REQ-028 5 AWs, no W, MaxTrans=4 -> aw_ready_o=0 after 4th; 5th accepted after first w_last.
REQ-029 r_ready_i toggled 0/1 during len=7 burst -> outputs stable while stalled, exactly 8 beats.
REQ-030 CntWidth=2, counter=2, B and R-last same cycle -> err_cnt_o=3; clr_i with concurrent handshake -> 0.
REQ-031 rst_i asserted mid R burst -> r_valid_o=0 immediately, busy_o=0, no further beats after release.

Source files
------------

// File: rtl/dram_err_responder.sv
// AXI-style error responder for unmapped DRAM space: every write gets a B error
// response, every read burst gets error-tagged R beats; completions are counted.

module dram_err_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    // Push is refused when full even if a pop happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end
endmodule

module dram_err_responder #(
    parameter int              IdWidth   = 6,
    parameter int              DataWidth = 64,
    parameter int              MaxTrans  = 4,
    parameter logic [1:0]      Resp      = 2'b11,
    parameter logic [63:0]     RespData  = 64'hCA11AB1EBADCAB1E,
    parameter int              CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    input  logic                 clr_i,
    output logic [CntWidth-1:0]  err_cnt_o,
    output logic                 busy_o
);
    function automatic logic [DataWidth-1:0] build_pattern();
        logic [DataWidth-1:0] p;
        for (int i = 0; i < DataWidth; i++) p[i] = RespData[i % 64];
        return p;
    endfunction

    localparam logic [DataWidth-1:0] RespPattern = build_pattern();

    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] cnt,
                                                    input logic [1:0]          inc);
        logic [CntWidth:0] sum;
        sum = {1'b0, cnt} + (CntWidth + 1)'(inc);
        return sum[CntWidth] ? '1 : sum[CntWidth-1:0];
    endfunction

    typedef enum logic {IDLE, BURST} r_state_t;

    logic               aw_empty, aw_full, aw_pop;
    logic [IdWidth-1:0] aw_head;
    logic               b_empty, b_full, b_hs;
    logic               ar_empty, ar_full, ar_pop;
    logic [IdWidth+7:0] ar_head;
    logic               w_hs, r_hs;
    r_state_t           state_q, state_d;
    logic [IdWidth-1:0] r_id_q;
    logic [7:0]         beat_cnt_q;
    logic [1:0]         cnt_inc;

    // Write path: AW ID parks until its last W beat, then moves to the B queue.
    assign aw_ready_o = ~aw_full;
    assign w_ready_o  = ~aw_empty & ~b_full;
    assign w_hs       = w_valid_i & w_ready_o;
    assign aw_pop     = w_hs & w_last_i;
    assign b_valid_o  = ~b_empty;
    assign b_resp_o   = Resp;
    assign b_hs       = b_valid_o & b_ready_i;

    dram_err_fifo #(.Width(IdWidth), .Depth(MaxTrans)) u_aw_q (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(aw_valid_i), .data_i(aw_id_i),
        .pop_i(aw_pop), .data_o(aw_head),
        .empty_o(aw_empty), .full_o(aw_full)
    );

    dram_err_fifo #(.Width(IdWidth), .Depth(MaxTrans)) u_b_q (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(aw_pop), .data_i(aw_head),
        .pop_i(b_hs), .data_o(b_id_o),
        .empty_o(b_empty), .full_o(b_full)
    );

    // Read path
    assign ar_ready_o = ~ar_full;
    assign r_hs       = (state_q == BURST) & r_ready_i;

    dram_err_fifo #(.Width(IdWidth + 8), .Depth(MaxTrans)) u_ar_q (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(ar_valid_i), .data_i({ar_id_i, ar_len_i}),
        .pop_i(ar_pop), .data_o(ar_head),
        .empty_o(ar_empty), .full_o(ar_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ar_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ar_empty) begin
                    ar_pop  = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (r_hs && beat_cnt_q == 8'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_valid_o = 1'b0;
        r_id_o    = '0;
        r_data_o  = '0;
        r_resp_o  = 2'b00;
        r_last_o  = 1'b0;
        if (state_q == BURST) begin
            r_valid_o = 1'b1;
            r_id_o    = r_id_q;
            r_data_o  = RespPattern;
            r_resp_o  = Resp;
            r_last_o  = (beat_cnt_q == 8'd0);
        end
    end

    // Burst bookkeeping is only observed in BURST, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (ar_pop)    {r_id_q, beat_cnt_q} <= ar_head;
        else if (r_hs) beat_cnt_q <= beat_cnt_q - 8'd1;
    end

    assign cnt_inc = {1'b0, b_hs} + {1'b0, r_hs & r_last_o};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      err_cnt_o <= '0;
        else if (clr_i) err_cnt_o <= '0;
        else            err_cnt_o <= sat_add(err_cnt_o, cnt_inc);
    end

    assign busy_o = ~aw_empty | ~b_empty | ~ar_empty | (state_q == BURST);
endmodule

// File: tb/tb_dram_err_responder.sv
// Directed self-checking bench for dram_err_responder; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.

module tb_dram_err_responder;
    localparam logic [63:0] Pat = 64'hCA11AB1EBADCAB1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, clr;
    logic [5:0]  aw_id, ar_id;
    logic [7:0]  ar_len;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, busy;
    logic [5:0]  b_id, r_id;
    logic [1:0]  b_resp, r_resp;
    logic [63:0] r_data;
    logic [15:0] err_cnt;
    logic        aw_ready2, w_ready2, b_valid2, ar_ready2, r_valid2, r_last2, busy2;
    logic [5:0]  b_id2, r_id2;
    logic [1:0]  b_resp2, r_resp2;
    logic [63:0] r_data2;
    logic [1:0]  err_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dram_err_responder dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .clr_i(clr), .err_cnt_o(err_cnt), .busy_o(busy)
    );

    dram_err_responder #(.CntWidth(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready2), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_o(w_ready2), .w_last_i(w_last),
        .b_valid_o(b_valid2), .b_ready_i(b_ready), .b_id_o(b_id2), .b_resp_o(b_resp2),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready2), .ar_id_i(ar_id), .ar_len_i(ar_len),
        .r_valid_o(r_valid2), .r_ready_i(r_ready), .r_id_o(r_id2), .r_data_o(r_data2),
        .r_resp_o(r_resp2), .r_last_o(r_last2),
        .clr_i(clr), .err_cnt_o(err_cnt2), .busy_o(busy2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        aw_valid = 0; aw_id = 0; w_valid = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_len = 0; r_ready = 0; clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
    endtask

    // Issues one AW and a single-beat W; returns at the negedge where B is visible.
    task automatic write_one(input logic [5:0] id);
        aw_valid = 1; aw_id = id;
        tick();
        aw_valid = 0; w_valid = 1; w_last = 1;
        tick();
        w_valid = 0; w_last = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); #1;
        tests++; if (aw_ready !== 1'b1) begin fails++; $display("FAIL rst_aw_ready: got %0b want 1", aw_ready); end
        tests++; if (ar_ready !== 1'b1) begin fails++; $display("FAIL rst_ar_ready: got %0b want 1", ar_ready); end
        tests++; if (w_ready !== 1'b0) begin fails++; $display("FAIL rst_w_ready: got %0b want 0", w_ready); end
        tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL rst_b_valid: got %0b want 0", b_valid); end
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL rst_r_valid: got %0b want 0", r_valid); end
        tests++; if (r_data !== 64'h0) begin fails++; $display("FAIL rst_r_data: got %0h want 0", r_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
        tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        rst = 0;
        tick();
    endtask

    task automatic test_write();
        do_reset();
        aw_valid = 1; aw_id = 6'd5;
        #1;
        tests++; if (aw_ready !== 1'b1) begin fails++; $display("FAIL wr_aw_ready: got %0b want 1", aw_ready); end
        tests++; if (w_ready !== 1'b0) begin fails++; $display("FAIL wr_w_early: got %0b want 0", w_ready); end
        tick();
        aw_valid = 0;
        for (int beat = 0; beat < 3; beat++) begin
            w_valid = 1; w_last = (beat == 2);
            #1;
            tests++; if (w_ready !== 1'b1) begin fails++; $display("FAIL wr_w_ready beat %0d: got %0b want 1", beat, w_ready); end
            tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL wr_b_early beat %0d: got %0b want 0", beat, b_valid); end
            tick();
        end
        w_valid = 0; w_last = 0; b_ready = 1;
        #1;
        tests++; if (b_valid !== 1'b1) begin fails++; $display("FAIL wr_b_valid: got %0b want 1", b_valid); end
        tests++; if (b_id !== 6'd5) begin fails++; $display("FAIL wr_b_id: got %0d want 5", b_id); end
        tests++; if (b_resp !== 2'b11) begin fails++; $display("FAIL wr_b_resp: got %0b want 11", b_resp); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy: got %0b want 1", busy); end
        tick();
        b_ready = 0;
        #1;
        tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL wr_b_drop: got %0b want 0", b_valid); end
        tests++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL wr_err_cnt: got %0d want 1", err_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_read();
        do_reset();
        ar_valid = 1; ar_id = 6'd3; ar_len = 8'd3; r_ready = 1;
        #1;
        tests++; if (ar_ready !== 1'b1) begin fails++; $display("FAIL rd_ar_ready: got %0b want 1", ar_ready); end
        tick();
        ar_valid = 0;
        #1;
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL rd_r_early: got %0b want 0", r_valid); end
        tick();
        for (int beat = 0; beat < 4; beat++) begin
            #1;
            tests++; if (r_valid !== 1'b1) begin fails++; $display("FAIL rd_r_valid beat %0d: got %0b want 1", beat, r_valid); end
            tests++; if (r_id !== 6'd3) begin fails++; $display("FAIL rd_r_id beat %0d: got %0d want 3", beat, r_id); end
            tests++; if (r_data !== Pat) begin fails++; $display("FAIL rd_r_data beat %0d: got %0h want %0h", beat, r_data, Pat); end
            tests++; if (r_resp !== 2'b11) begin fails++; $display("FAIL rd_r_resp beat %0d: got %0b want 11", beat, r_resp); end
            tests++; if (r_last !== (beat == 3)) begin fails++; $display("FAIL rd_r_last beat %0d: got %0b want %0b", beat, r_last, beat == 3); end
            tick();
        end
        r_ready = 0;
        #1;
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL rd_r_end: got %0b want 0", r_valid); end
        tests++; if (r_data !== 64'h0) begin fails++; $display("FAIL rd_r_data_idle: got %0h want 0", r_data); end
        tests++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL rd_err_cnt: got %0d want 1", err_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy: got %0b want 0", busy); end
    endtask

    task automatic test_aw_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            aw_valid = 1; aw_id = 6'(i);
            #1;
            tests++; if (aw_ready !== 1'b1) begin fails++; $display("FAIL full_aw_ready %0d: got %0b want 1", i, aw_ready); end
            tick();
        end
        aw_id = 6'd5; w_valid = 1; w_last = 1; b_ready = 1;
        #1;
        tests++; if (aw_ready !== 1'b0) begin fails++; $display("FAIL full_aw_blocked: got %0b want 0", aw_ready); end
        tick();
        w_valid = 0; w_last = 0;
        #1;
        tests++; if (aw_ready !== 1'b1) begin fails++; $display("FAIL full_aw_reopen: got %0b want 1", aw_ready); end
        tests++; if (b_id !== 6'd1) begin fails++; $display("FAIL full_b_id 1: got %0d want 1", b_id); end
        tick();
        aw_valid = 0;
        for (int k = 2; k <= 5; k++) begin
            w_valid = 1; w_last = 1;
            #1;
            tests++; if (w_ready !== 1'b1) begin fails++; $display("FAIL full_w_ready %0d: got %0b want 1", k, w_ready); end
            tick();
            w_valid = 0; w_last = 0;
            #1;
            tests++; if (b_id !== 6'(k) || b_valid !== 1'b1) begin fails++; $display("FAIL full_b_id %0d: got %0d/%0b want %0d/1", k, b_id, b_valid, k); end
            tick();
        end
        b_ready = 0;
        #1;
        tests++; if (err_cnt !== 16'd5) begin fails++; $display("FAIL full_err_cnt: got %0d want 5", err_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy: got %0b want 0", busy); end
    endtask

    task automatic test_r_stall();
        int beats = 0;
        logic [5:0] held_id;
        do_reset();
        ar_valid = 1; ar_id = 6'd7; ar_len = 8'd7;
        tick();
        ar_valid = 0;
        tick();
        for (int c = 0; c < 40; c++) begin
            r_ready = (c % 3 != 0);
            #1;
            if (r_valid) begin
                tests++; if (r_id !== 6'd7 || r_data !== Pat || r_resp !== 2'b11) begin fails++; $display("FAIL stall_fields cyc %0d: got %0d/%0h/%0b want 7/%0h/11", c, r_id, r_data, r_resp, Pat); end
                tests++; if (r_last !== (beats == 7)) begin fails++; $display("FAIL stall_last cyc %0d: got %0b want %0b", c, r_last, beats == 7); end
                if (r_ready) beats++;
            end
            tick();
        end
        held_id = r_id;
        r_ready = 0;
        #1;
        tests++; if (beats != 8) begin fails++; $display("FAIL stall_beats: got %0d want 8", beats); end
        tests++; if (r_valid !== 1'b0 || held_id !== 6'd0) begin fails++; $display("FAIL stall_end: got %0b/%0d want 0/0", r_valid, held_id); end
        tests++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL stall_err_cnt: got %0d want 1", err_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        b_ready = 1;
        write_one(6'd1);
        tick();
        write_one(6'd2);
        tick();
        b_ready = 0;
        #1;
        tests++; if (err_cnt2 !== 2'd2) begin fails++; $display("FAIL sat_pre: got %0d want 2", err_cnt2); end
        write_one(6'd3);
        ar_valid = 1; ar_id = 6'd4; ar_len = 8'd0;
        tick();
        ar_valid = 0;
        tick();
        #1;
        tests++; if (!(r_valid && r_last && b_valid)) begin fails++; $display("FAIL sat_setup: got r%0b l%0b b%0b want 111", r_valid, r_last, b_valid); end
        b_ready = 1; r_ready = 1;
        tick();
        b_ready = 0; r_ready = 0;
        #1;
        tests++; if (err_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_plus2: got %0d want 3", err_cnt2); end
        tests++; if (err_cnt !== 16'd4) begin fails++; $display("FAIL sat_wide: got %0d want 4", err_cnt); end
        b_ready = 1;
        write_one(6'd5);
        tick();
        b_ready = 0;
        #1;
        tests++; if (err_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_hold: got %0d want 3", err_cnt2); end
        tests++; if (err_cnt !== 16'd5) begin fails++; $display("FAIL sat_wide2: got %0d want 5", err_cnt); end
        write_one(6'd6);
        b_ready = 1; clr = 1;
        tick();
        b_ready = 0; clr = 0;
        #1;
        tests++; if (err_cnt2 !== 2'd0) begin fails++; $display("FAIL clr_narrow: got %0d want 0", err_cnt2); end
        tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL clr_wide: got %0d want 0", err_cnt); end
        tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL clr_b_done: got %0b want 0", b_valid); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ar_valid = 1; ar_id = 6'd9; ar_len = 8'd7; r_ready = 1;
        tick();
        ar_valid = 0;
        tick(); tick(); tick(); tick();
        #1;
        tests++; if (r_valid !== 1'b1) begin fails++; $display("FAIL mid_in_burst: got %0b want 1", r_valid); end
        rst = 1;
        #1;
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL mid_r_valid: got %0b want 0", r_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %0b want 0", busy); end
        tests++; if (ar_ready !== 1'b1 || aw_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %0b%0b want 11", ar_ready, aw_ready); end
        tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
        tick();
        rst = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            tests++; if (r_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_after cyc %0d: got v%0b b%0b want 00", c, r_valid, busy); end
        end
        r_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_write();
        test_read();
        test_aw_full();
        test_r_stall();
        test_saturate();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
